unified_mem_ctrl: RTL and testbench

UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

---
 rtl/unified_mem_ctrl_if.sv | 35 +++
 rtl/unified_mem_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_unified_mem_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_ctrl_if.sv
// Bus bundle for unified_mem_ctrl: fetch port, data port and FSM/arbiter debug taps.
// Handshake: a requester raises *_req with stable inputs until it samples *_gnt high;
// the matching *_valid pulses for one cycle after the access completes.
interface unified_mem_ctrl_if #(
   parameter int ADDR_W = 12
) ();
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [31:0]       if_rdata;
   logic              d_req;
   logic              d_we;
   logic [2:0]        d_func3;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [31:0]       d_rdata;
   logic              d_misalign;
   logic              dbg_state;
   logic              dbg_prio;

   modport master (
      output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata,
      input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_misalign,
      input  dbg_state, dbg_prio
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata,
      output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_misalign,
      output dbg_state, dbg_prio
   );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Single-port byte memory shared by instruction fetch and RV32 loads/stores.
// Define UMEM_MISALIGN_SPLIT_EN to run misaligned accesses as two beats via SPLIT.
module unified_mem_ctrl #(
   parameter int DEPTH_BYTES = 4096,
   parameter int ADDR_W      = 12,
   parameter int DATA_BASE   = 256
) (
   input logic               clk,
   input logic               rst,
   unified_mem_ctrl_if.slave bus
);
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_SPLIT   = 1'b1;
   localparam logic       PRIO_DATA  = 1'b0;
   localparam logic       PRIO_FETCH = 1'b1;
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(DATA_BASE % DEPTH_BYTES);

   function automatic logic [2:0] byte_cnt(input logic we, input logic [2:0] f3);
      case (f3)
         3'b000:  byte_cnt = 3'd1;
         3'b001:  byte_cnt = 3'd2;
         3'b010:  byte_cnt = 3'd4;
         3'b100:  byte_cnt = we ? 3'd0 : 3'd1;
         3'b101:  byte_cnt = we ? 3'd0 : 3'd2;
         default: byte_cnt = 3'd0;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic [2:0] n;
      n = byte_cnt(we, f3);
      return ((n == 3'd2) && a[0]) || ((n == 3'd4) && (a != 2'b00));
   endfunction

   function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  load_fmt = {{24{w[7]}}, w[7:0]};
         3'b001:  load_fmt = {{16{w[15]}}, w[15:0]};
         3'b010:  load_fmt = w;
         3'b100:  load_fmt = {24'd0, w[7:0]};
         3'b101:  load_fmt = {16'd0, w[15:0]};
         default: load_fmt = 32'd0;
      endcase
   endfunction

   logic [7:0]        mem_q [DEPTH_BYTES];
   logic [0:0]        state_q, state_d;
   logic              prio_q, prio_d;
   logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d, d_mis_q, d_mis_d;
   logic [31:0]       if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic              if_gnt, d_gnt;
   logic              acc_we, acc_mis;
   logic [2:0]        acc_f3, acc_n;
   logic [ADDR_W-1:0] acc_pa;
   logic [31:0]       acc_wd, rd_word;
   logic [ADDR_W-1:0] lane_a [4];
   logic [3:0]        in_acc, lane_sel, wr_en;
`ifdef UMEM_MISALIGN_SPLIT_EN
   logic              sp_we_q, sp_we_d;
   logic [2:0]        sp_f3_q, sp_f3_d;
   logic [ADDR_W-1:0] sp_pa_q, sp_pa_d;
   logic [31:0]       sp_wd_q, sp_wd_d, sp_buf_q, sp_buf_d;
   logic [3:0]        lo_lane;
   logic [31:0]       merged;
`endif

   // Grants only from IDLE and never while reset is held, so reset cannot start a write.
   always_comb begin
      d_gnt  = 1'b0;
      if_gnt = 1'b0;
      prio_d = prio_q;
      if (state_q == ST_IDLE && !rst) begin
         if (bus.d_req && (!bus.if_req || prio_q == PRIO_DATA)) d_gnt = 1'b1;
         else if (bus.if_req)                                    if_gnt = 1'b1;
         if (bus.d_req && bus.if_req) prio_d = d_gnt ? PRIO_FETCH : PRIO_DATA;
      end
   end

   // One shared address path: fetch, data beat or the saved second beat.
   always_comb begin
      acc_we = bus.d_we;
      acc_f3 = bus.d_func3;
      acc_wd = bus.d_wdata;
      acc_pa = if_gnt ? bus.if_addr : bus.d_addr + BASE_A;
`ifdef UMEM_MISALIGN_SPLIT_EN
      if (state_q == ST_SPLIT) begin
         acc_we = sp_we_q;
         acc_f3 = sp_f3_q;
         acc_wd = sp_wd_q;
         acc_pa = sp_pa_q;
      end
`endif
      acc_n   = byte_cnt(acc_we, acc_f3);
      acc_mis = is_misaligned(bus.d_we, bus.d_func3, bus.d_addr[1:0]);
      for (int i = 0; i < 4; i++) begin
         lane_a[i]          = acc_pa + ADDR_W'(i);
         in_acc[i]          = 3'(i) < acc_n;
         rd_word[8*i +: 8]  = mem_q[lane_a[i]];
      end
   end

`ifdef UMEM_MISALIGN_SPLIT_EN
   // Beat 1 owns the lanes that stay below the next 4-byte boundary.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lo_lane[i]        = ({1'b0, acc_pa[1:0]} + 3'(i)) < 3'd4;
         merged[8*i +: 8]  = lo_lane[i] ? sp_buf_q[8*i +: 8] : rd_word[8*i +: 8];
      end
   end
`endif

   always_comb begin
      state_d    = ST_IDLE;
      if_valid_d = 1'b0;
      d_valid_d  = 1'b0;
      d_mis_d    = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      lane_sel   = 4'b0000;
`ifdef UMEM_MISALIGN_SPLIT_EN
      sp_we_d  = sp_we_q;
      sp_f3_d  = sp_f3_q;
      sp_pa_d  = sp_pa_q;
      sp_wd_d  = sp_wd_q;
      sp_buf_d = sp_buf_q;
`endif
      if (if_gnt) begin
         if_valid_d = 1'b1;
         if_rdata_d = rd_word;
      end
      if (d_gnt) begin
         if (acc_mis) begin
`ifdef UMEM_MISALIGN_SPLIT_EN
            state_d  = ST_SPLIT;
            lane_sel = in_acc & lo_lane;
            sp_we_d  = bus.d_we;
            sp_f3_d  = bus.d_func3;
            sp_pa_d  = acc_pa;
            sp_wd_d  = bus.d_wdata;
            sp_buf_d = rd_word;
`else
            d_valid_d = 1'b1;
            d_mis_d   = 1'b1;
            if (!acc_we) d_rdata_d = 32'd0;
`endif
         end else begin
            lane_sel  = in_acc;
            d_valid_d = 1'b1;
            if (!acc_we) d_rdata_d = load_fmt(acc_f3, rd_word);
         end
      end
`ifdef UMEM_MISALIGN_SPLIT_EN
      if (state_q == ST_SPLIT) begin
         lane_sel  = in_acc & ~lo_lane;
         d_valid_d = 1'b1;
         if (!acc_we) d_rdata_d = load_fmt(acc_f3, merged);
      end
`endif
      wr_en = rst ? 4'b0000 : (lane_sel & {4{acc_we}});
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (wr_en[i]) mem_q[lane_a[i]] <= acc_wd[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         prio_q     <= PRIO_DATA;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         d_mis_q    <= 1'b0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         if_valid_q <= if_valid_d;
         d_valid_q  <= d_valid_d;
         d_mis_q    <= d_mis_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef UMEM_MISALIGN_SPLIT_EN
   always_ff @(posedge clk) begin
      sp_we_q  <= sp_we_d;
      sp_f3_q  <= sp_f3_d;
      sp_pa_q  <= sp_pa_d;
      sp_wd_q  <= sp_wd_d;
      sp_buf_q <= sp_buf_d;
   end
`endif

   assign bus.if_gnt     = if_gnt;
   assign bus.d_gnt      = d_gnt;
   assign bus.if_valid   = if_valid_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_valid    = d_valid_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.d_misalign = d_mis_q;
   assign bus.dbg_state  = state_q;
   assign bus.dbg_prio   = prio_q;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl; expectations follow UMEM_MISALIGN_SPLIT_EN when defined.
module tb_unified_mem_ctrl;
   localparam int ADDR_W = 12;

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [11:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
      logic [1:0]  lat;
      logic        mis;
   } op_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   unified_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   unified_mem_ctrl #(.DEPTH_BYTES(4096), .ADDR_W(ADDR_W), .DATA_BASE(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive_idle();
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_func3 = 3'b000;
      bus.d_addr  = '0;
      bus.d_wdata = 32'd0;
   endtask

   // Returns grant wait (-1 on timeout), cycles to d_valid (0 on timeout), result,
   // and tail=1 if d_misalign leaked without d_valid or d_valid lasted past one cycle.
   task automatic data_op(input logic we, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] wd, output int gw, output int lat,
                          output logic [31:0] rd, output logic mis, output logic tail);
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_func3 = f3; bus.d_addr = a; bus.d_wdata = wd;
      #1;
      gw = 0; lat = 0; rd = '0; mis = 1'b0; tail = 1'b1;
      while (bus.d_gnt !== 1'b1 && gw < 16) begin @(negedge clk); #1; gw++; end
      if (bus.d_gnt === 1'b1) begin
         @(negedge clk);
         bus.d_req = 1'b0;
         lat = 1; tail = 1'b0;
         while (bus.d_valid !== 1'b1 && lat < 4) begin
            if (bus.d_misalign !== 1'b0) tail = 1'b1;
            @(negedge clk);
            lat++;
         end
         if (bus.d_valid !== 1'b1) lat = 0;
         rd = bus.d_rdata; mis = bus.d_misalign;
         @(negedge clk);
         if (bus.d_valid !== 1'b0 || bus.d_misalign !== 1'b0) tail = 1'b1;
      end else begin
         gw = -1;
      end
      bus.d_req = 1'b0;
   endtask

   task automatic fetch_op(input logic [11:0] a, output int gw, output int lat,
                           output logic [31:0] rd, output logic tail);
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = a;
      #1;
      gw = 0; lat = 0; rd = '0; tail = 1'b1;
      while (bus.if_gnt !== 1'b1 && gw < 16) begin @(negedge clk); #1; gw++; end
      if (bus.if_gnt === 1'b1) begin
         @(negedge clk);
         bus.if_req = 1'b0;
         lat = 1; tail = 1'b0;
         while (bus.if_valid !== 1'b1 && lat < 4) begin @(negedge clk); lat++; end
         if (bus.if_valid !== 1'b1) lat = 0;
         rd = bus.if_rdata;
         @(negedge clk);
         if (bus.if_valid !== 1'b0) tail = 1'b1;
      end else begin
         gw = -1;
      end
      bus.if_req = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.dbg_state !== 1'b0)  begin errors++; $display("FAIL reset.state got %b want 0", bus.dbg_state); end
      checks++; if (bus.dbg_prio !== 1'b0)   begin errors++; $display("FAIL reset.prio got %b want 0", bus.dbg_prio); end
      checks++; if (bus.if_valid !== 1'b0)   begin errors++; $display("FAIL reset.if_valid got %b want 0", bus.if_valid); end
      checks++; if (bus.d_valid !== 1'b0)    begin errors++; $display("FAIL reset.d_valid got %b want 0", bus.d_valid); end
      checks++; if (bus.d_misalign !== 1'b0) begin errors++; $display("FAIL reset.d_misalign got %b want 0", bus.d_misalign); end
      checks++; if (bus.if_rdata !== 32'd0)  begin errors++; $display("FAIL reset.if_rdata got %h want 0", bus.if_rdata); end
      checks++; if (bus.d_rdata !== 32'd0)   begin errors++; $display("FAIL reset.d_rdata got %h want 0", bus.d_rdata); end
      rst = 1'b0;
   endtask

   task automatic test_load_store();
      op_t tab [21];
      int gw, lat;
      logic [31:0] rd;
      logic mis, tail;
      tab = '{
         {1'b1, 3'b010, 12'd0,    32'd17,        32'd0,         2'd1, 1'b0},
         {1'b0, 3'b010, 12'd0,    32'd0,         32'd17,        2'd1, 1'b0},
         {1'b1, 3'b000, 12'd0,    32'h000000F0,  32'd0,         2'd1, 1'b0},
         {1'b0, 3'b000, 12'd0,    32'd0,         32'hFFFFFFF0,  2'd1, 1'b0},
         {1'b0, 3'b100, 12'd0,    32'd0,         32'h000000F0,  2'd1, 1'b0},
         {1'b1, 3'b001, 12'd2,    32'hFFFF8765,  32'd0,         2'd1, 1'b0},
         {1'b0, 3'b001, 12'd2,    32'd0,         32'hFFFF8765,  2'd1, 1'b0},
         {1'b0, 3'b101, 12'd2,    32'd0,         32'h00008765,  2'd1, 1'b0},
         {1'b0, 3'b010, 12'd0,    32'd0,         32'h876500F0,  2'd1, 1'b0},
         {1'b0, 3'b011, 12'd0,    32'd0,         32'd0,         2'd1, 1'b0},
         {1'b0, 3'b110, 12'd0,    32'd0,         32'd0,         2'd1, 1'b0},
         {1'b1, 3'b011, 12'd0,    32'hFFFFFFFF,  32'd0,         2'd1, 1'b0},
         {1'b0, 3'b010, 12'd0,    32'd0,         32'h876500F0,  2'd1, 1'b0},
         {1'b1, 3'b000, 12'd1,    32'h1234565A,  32'd0,         2'd1, 1'b0},
         {1'b0, 3'b010, 12'd0,    32'd0,         32'h87655AF0,  2'd1, 1'b0},
         {1'b0, 3'b000, 12'd1,    32'd0,         32'h0000005A,  2'd1, 1'b0},
         {1'b1, 3'b001, 12'd3838, 32'h0000BBAA,  32'd0,         2'd1, 1'b0},
         {1'b1, 3'b001, 12'd3840, 32'h0000DDCC,  32'd0,         2'd1, 1'b0},
         {1'b0, 3'b101, 12'd3840, 32'd0,         32'h0000DDCC,  2'd1, 1'b0},
         {1'b1, 3'b000, 12'd4095, 32'h0000007F,  32'd0,         2'd1, 1'b0},
         {1'b0, 3'b100, 12'd4095, 32'd0,         32'h0000007F,  2'd1, 1'b0}
      };
      for (int i = 0; i < 21; i++) begin
         data_op(tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, gw, lat, rd, mis, tail);
         checks++;
         if (gw !== 0 || lat !== 1 || mis !== 1'b0 || tail !== 1'b0) begin
            errors++;
            $display("FAIL ls[%0d] gw/lat/mis/tail got %0d/%0d/%b/%b want 0/1/0/0", i, gw, lat, mis, tail);
         end
         if (!tab[i].we) begin
            checks++;
            if (rd !== tab[i].exp) begin errors++; $display("FAIL ls[%0d].rdata got %h want %h", i, rd, tab[i].exp); end
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_func3 = 3'b010; bus.d_addr = 12'd8; bus.d_wdata = 32'h12345678;
      #1;
      checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL b2b.store_gnt got %b want 1", bus.d_gnt); end
      @(negedge clk);
      bus.d_we = 1'b0; bus.d_wdata = 32'd0;
      #1;
      checks++; if (bus.d_valid !== 1'b1) begin errors++; $display("FAIL b2b.store_valid got %b want 1", bus.d_valid); end
      checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL b2b.load_gnt got %b want 1", bus.d_gnt); end
      @(negedge clk);
      bus.d_req = 1'b0;
      checks++; if (bus.d_valid !== 1'b1) begin errors++; $display("FAIL b2b.load_valid got %b want 1", bus.d_valid); end
      checks++; if (bus.d_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b.rdata got %h want 12345678", bus.d_rdata); end
      @(negedge clk);
      checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL b2b.valid_drop got %b want 0", bus.d_valid); end
   endtask

   task automatic test_fetch();
      int gw, lat;
      logic [31:0] rd;
      logic tail;
      fetch_op(12'd256, gw, lat, rd, tail);
      checks++; if (gw !== 0 || lat !== 1 || tail !== 1'b0) begin errors++; $display("FAIL fetch256 gw/lat/tail got %0d/%0d/%b want 0/1/0", gw, lat, tail); end
      checks++; if (rd !== 32'h87655AF0) begin errors++; $display("FAIL fetch256.rdata got %h want 87655af0", rd); end
      fetch_op(12'd4094, gw, lat, rd, tail);
      checks++; if (gw !== 0 || lat !== 1 || tail !== 1'b0) begin errors++; $display("FAIL fetch4094 gw/lat/tail got %0d/%0d/%b want 0/1/0", gw, lat, tail); end
      checks++; if (rd !== 32'hDDCCBBAA) begin errors++; $display("FAIL fetch4094.rdata got %h want ddccbbaa", rd); end
   endtask

   task automatic test_misalign();
      op_t tab [6];
      int gw, lat;
      logic [31:0] rd;
      logic mis, tail;
`ifdef UMEM_MISALIGN_SPLIT_EN
      tab = '{
         {1'b1, 3'b010, 12'd1,    32'hAABBCCDD, 32'd0,        2'd2, 1'b0},
         {1'b0, 3'b010, 12'd1,    32'd0,        32'hAABBCCDD, 2'd2, 1'b0},
         {1'b0, 3'b010, 12'd0,    32'd0,        32'hBBCCDDF0, 2'd1, 1'b0},
         {1'b0, 3'b100, 12'd4,    32'd0,        32'h000000AA, 2'd1, 1'b0},
         {1'b0, 3'b001, 12'd4095, 32'd0,        32'hFFFFF07F, 2'd2, 1'b0},
         {1'b0, 3'b101, 12'd4095, 32'd0,        32'h0000F07F, 2'd2, 1'b0}
      };
`else
      tab = '{
         {1'b1, 3'b010, 12'd1,    32'hAABBCCDD, 32'd0,        2'd1, 1'b1},
         {1'b0, 3'b010, 12'd0,    32'd0,        32'h87655AF0, 2'd1, 1'b0},
         {1'b0, 3'b010, 12'd1,    32'd0,        32'd0,        2'd1, 1'b1},
         {1'b0, 3'b001, 12'd4095, 32'd0,        32'd0,        2'd1, 1'b1},
         {1'b0, 3'b001, 12'd2,    32'd0,        32'hFFFF8765, 2'd1, 1'b0},
         {1'b0, 3'b000, 12'd1,    32'd0,        32'h0000005A, 2'd1, 1'b0}
      };
`endif
      for (int i = 0; i < 6; i++) begin
         data_op(tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, gw, lat, rd, mis, tail);
         checks++;
         if (gw !== 0 || lat !== int'(tab[i].lat) || mis !== tab[i].mis || tail !== 1'b0) begin
            errors++;
            $display("FAIL mis[%0d] gw/lat/mis/tail got %0d/%0d/%b/%b want 0/%0d/%b/0", i, gw, lat, mis, tail, tab[i].lat, tab[i].mis);
         end
         if (!tab[i].we) begin
            checks++;
            if (rd !== tab[i].exp) begin errors++; $display("FAIL mis[%0d].rdata got %h want %h", i, rd, tab[i].exp); end
         end
      end
   endtask

`ifdef UMEM_MISALIGN_SPLIT_EN
   task automatic test_split_reset();
      int gw, lat;
      logic [31:0] rd;
      logic mis, tail;
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_func3 = 3'b010; bus.d_addr = 12'd5; bus.d_wdata = 32'h11223344;
      #1;
      checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL srst.gnt got %b want 1", bus.d_gnt); end
      @(negedge clk);
      bus.d_req = 1'b0; rst = 1'b1;
      checks++; if (bus.dbg_state !== 1'b1) begin errors++; $display("FAIL srst.in_split got %b want 1", bus.dbg_state); end
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL srst.state got %b want 0", bus.dbg_state); end
      checks++; if (bus.d_valid !== 1'b0 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL srst.valids got %b%b want 00", bus.d_valid, bus.if_valid); end
      @(negedge clk);
      checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL srst.late_valid got %b want 0", bus.d_valid); end
      data_op(1'b0, 3'b100, 12'd8, 32'd0, gw, lat, rd, mis, tail);
      checks++; if (rd !== 32'h00000078) begin errors++; $display("FAIL srst.beat2_byte got %h want 00000078", rd); end
      data_op(1'b0, 3'b100, 12'd5, 32'd0, gw, lat, rd, mis, tail);
      checks++; if (rd !== 32'h00000044) begin errors++; $display("FAIL srst.beat1_byte got %h want 00000044", rd); end
   endtask
`endif

   task automatic test_reset_keeps_mem();
      int gw, lat;
      logic [31:0] rd, exp_w;
      logic mis, tail;
`ifdef UMEM_MISALIGN_SPLIT_EN
      exp_w = 32'hBBCCDDF0;
`else
      exp_w = 32'h87655AF0;
`endif
      test_reset();
      data_op(1'b0, 3'b010, 12'd0, 32'd0, gw, lat, rd, mis, tail);
      checks++; if (rd !== exp_w) begin errors++; $display("FAIL keep_mem.rdata got %h want %h", rd, exp_w); end
   endtask

   task automatic test_arbitration();
      logic [31:0] exp_q[$];
      logic [31:0] exp_f, exp_d;
      logic [31:0] want;
`ifdef UMEM_MISALIGN_SPLIT_EN
      exp_f = 32'hBBCCDDF0;
`else
      exp_f = 32'h87655AF0;
`endif
      exp_d = 32'h12345678;
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_func3 = 3'b010; bus.d_addr = 12'd8;
      bus.if_req = 1'b1; bus.if_addr = 12'd256;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) begin bus.d_req = 1'b0; bus.if_req = 1'b0; end
         #1;
         if (c > 0) begin
            checks++;
            if ({bus.d_valid, bus.if_valid} !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL arb[%0d].valids got %b%b want %s", c, bus.d_valid, bus.if_valid, (c % 2 == 1) ? "10" : "01");
            end
            if (exp_q.size() > 0) begin
               want = exp_q.pop_front();
               checks++;
               if ((bus.d_valid ? bus.d_rdata : bus.if_rdata) !== want) begin
                  errors++; $display("FAIL arb[%0d].rdata got %h want %h", c, bus.d_valid ? bus.d_rdata : bus.if_rdata, want);
               end
            end
         end
         if (c < 4) begin
            checks++;
            if ({bus.d_gnt, bus.if_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL arb[%0d].gnt got %b%b want %s", c, bus.d_gnt, bus.if_gnt, (c % 2 == 0) ? "10" : "01");
            end
            if (bus.d_gnt) exp_q.push_back(exp_d);
            if (bus.if_gnt) exp_q.push_back(exp_f);
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL arb.queue left %0d want 0", exp_q.size()); end
      bus.if_req = 1'b1;
      #1;
      checks++; if ({bus.d_gnt, bus.if_gnt} !== 2'b01) begin errors++; $display("FAIL arb.sole_fetch got %b%b want 01", bus.d_gnt, bus.if_gnt); end
      @(negedge clk);
      bus.d_req = 1'b1;
      #1;
      checks++; if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin errors++; $display("FAIL arb.after_sole got %b%b want 10", bus.d_gnt, bus.if_gnt); end
      @(negedge clk);
      #1;
      checks++; if ({bus.d_gnt, bus.if_gnt} !== 2'b01) begin errors++; $display("FAIL arb.flip got %b%b want 01", bus.d_gnt, bus.if_gnt); end
      @(negedge clk);
      drive_idle();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      drive_idle();
      rst = 1'b1;
      test_reset();
      test_load_store();
      test_back_to_back();
      test_fetch();
      test_misalign();
`ifdef UMEM_MISALIGN_SPLIT_EN
      test_split_reset();
`endif
      test_reset_keeps_mem();
      test_reset();
      test_arbitration();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
